spi_slave: RTL and testbench

//  SPI mode-0 peripheral (target) port, MSB first, one byte per 8 SCK cycles. Lets an external
//  SPI master (e.g. a board controller) exchange bytes with the core. SCK, SS_N and MOSI are

---
 rtl/spi_slave_if.sv | 17 +
 rtl/spi_slave.sv | 101 ++++++++++
 tb/tb_spi_slave.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the core-side byte port of the SPI peripheral
interface spi_slave_if;
   logic       sck;
   logic       ss_n;
   logic       mosi;
   logic       miso;
   logic       oe;
   logic [7:0] d;
   logic       ld;
   logic       txe;
   logic [7:0] q;
   logic       rdy;
   logic       first;
   logic       sel;
   modport slave  (input sck, ss_n, mosi, d, ld, output miso, oe, txe, q, rdy, first, sel);
   modport master (output sck, ss_n, mosi, d, ld, input miso, oe, txe, q, rdy, first, sel);
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI mode-0 target, MSB first, byte port with single-entry tx holding register
module spi_slave #(
   parameter logic [7:0] FILL = 8'hFF
) (
   input logic        clock,
   input logic        reset,
   spi_slave_if.slave s
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t     state, state_nx;
   logic [2:0] sck_r, ss_r;
   logic [1:0] mosi_r;
   logic [2:0] bitcnt;
   logic [7:0] rx, tx, hold, q, rx_nx, tx_ld;
   logic       rdy, first, fsf, txe;
   logic       rise, fall, ss_fall, ss_hi, act, start, consume, done;

   // two-flop synchronizers; the third sck/ss_n stage is the edge-detect history
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         sck_r  <= '0;
         ss_r   <= '1;
         mosi_r <= '0;
      end else begin
         sck_r  <= {sck_r[1:0], s.sck};
         ss_r   <= {ss_r[1:0], s.ss_n};
         mosi_r <= {mosi_r[0], s.mosi};
      end

   // frame state register
   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nx;

   // next state plus per-cycle decodes; a deselect mid-ACTIVE suppresses edge handling
   always_comb begin
      rise     = sck_r[1] & ~sck_r[2];
      fall     = ~sck_r[1] & sck_r[2];
      ss_fall  = ~ss_r[1] & ss_r[2];
      ss_hi    = ss_r[1];
      state_nx = (state == IDLE) ? (ss_fall ? ACTIVE : IDLE) : (ss_hi ? IDLE : ACTIVE);
      act      = (state == ACTIVE) & ~ss_hi;
      start    = (state == IDLE) & ss_fall;
      consume  = start | (act & fall & (bitcnt == 3'd0));
      done     = act & rise & (bitcnt == 3'd7);
      rx_nx    = {rx[6:0], mosi_r[1]};
      tx_ld    = txe ? FILL : hold;
   end

   // receive shifter, bit counter, byte output and frame-start tracking
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         rx     <= '0;
         bitcnt <= '0;
         q      <= '0;
         rdy    <= 1'b0;
         first  <= 1'b0;
         fsf    <= 1'b1;
      end else begin
         rdy <= done;
         if (state == IDLE) begin
            rx     <= '0;
            bitcnt <= '0;
            fsf    <= 1'b1;
         end else if (act & rise) begin
            rx     <= rx_nx;
            bitcnt <= bitcnt + 3'd1;
         end
         if (done) begin
            q     <= rx_nx;
            first <= fsf;
            fsf   <= 1'b0;
         end
      end

   // transmit shifter: reload at frame start and byte boundaries, else shift on sck fall
   always_ff @(posedge clock or negedge reset)
      if (!reset)             tx <= '0;
      else if (consume)       tx <= tx_ld;
      else if (act & fall)    tx <= {tx[6:0], 1'b0};

   // holding register: a write wins over a same-cycle consume, which already took the old value
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         hold <= '0;
         txe  <= 1'b1;
      end else if (s.ld) begin
         hold <= s.d;
         txe  <= 1'b0;
      end else if (consume) begin
         txe  <= 1'b1;
      end

   assign s.miso  = (state == ACTIVE) ? tx[7] : 1'b1;
   assign s.oe    = (state == ACTIVE);
   assign s.sel   = (state == ACTIVE);
   assign s.txe   = txe;
   assign s.q     = q;
   assign s.rdy   = rdy;
   assign s.first = first;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master transactions against spi_slave with hand-computed expectations
module tb_spi_slave;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   int         checks = 0;
   int         failures = 0;
   logic [7:0] qq[$];
   logic       fq[$];
   logic [7:0] mi;
   int         b;

   spi_slave_if sif();
   spi_slave #(.FILL(8'hFF)) dut (.clock(clock), .reset(reset), .s(sif));

   always #5 clock = ~clock;

   // record every rdy strobe with its byte and first flag
   always @(negedge clock)
      if (sif.rdy === 1'b1) begin
         qq.push_back(sif.q);
         fq.push_back(sif.first);
      end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_ld(input logic [7:0] v);
      sif.d  = v;
      sif.ld = 1'b1;
      @(negedge clock);
      sif.ld = 1'b0;
   endtask

   task automatic sel_on();
      sif.ss_n = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   task automatic sel_off();
      repeat (6) @(negedge clock);
      sif.ss_n = 1'b1;
      repeat (6) @(negedge clock);
   endtask

   // n mode-0 bits; miso is sampled at the end of each high phase
   task automatic bits(input logic [7:0] mo, input int n, input int half,
                       input logic ldx, input logic [7:0] ldd, output logic [7:0] r);
      r = '0;
      for (int i = 0; i < n; i++) begin
         sif.mosi = mo[3'(7 - i)];
         repeat (half) @(negedge clock);
         sif.sck = 1'b1;
         repeat (half) @(negedge clock);
         r[3'(7 - i)] = sif.miso;
         sif.sck = 1'b0;
      end
      if (ldx) begin
         repeat (2) @(negedge clock);
         pulse_ld(ldd);
      end
   endtask

   initial begin
      sif.sck = 1'b0; sif.ss_n = 1'b1; sif.mosi = 1'b0; sif.d = '0; sif.ld = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_q", sif.q, 8'h00);
      chk("rst_rdy", {7'b0, sif.rdy}, 8'd0);
      chk("rst_first", {7'b0, sif.first}, 8'd0);
      chk("rst_sel", {7'b0, sif.sel}, 8'd0);
      chk("rst_oe", {7'b0, sif.oe}, 8'd0);
      chk("rst_miso", {7'b0, sif.miso}, 8'd1);
      chk("rst_txe", {7'b0, sif.txe}, 8'd1);
      reset = 1'b1;
      repeat (3) @(negedge clock);

      // 1: single byte A5, holding 3C
      pulse_ld(8'h3C);
      chk("t1_txe_full", {7'b0, sif.txe}, 8'd0);
      b = qq.size();
      sel_on();
      chk("t1_sel", {7'b0, sif.sel}, 8'd1);
      chk("t1_oe", {7'b0, sif.oe}, 8'd1);
      chk("t1_txe_cons", {7'b0, sif.txe}, 8'd1);
      bits(8'hA5, 8, 4, 1'b0, 8'h00, mi);
      chk("t1_miso", mi, 8'h3C);
      sel_off();
      chk("t1_cnt", 8'(qq.size() - b), 8'd1);
      chk("t1_q", qq[b], 8'hA5);
      chk("t1_first", {7'b0, fq[b]}, 8'd1);
      chk("t1_idle_miso", {7'b0, sif.miso}, 8'd1);
      chk("t1_idle_oe", {7'b0, sif.oe}, 8'd0);

      // 2: three bytes, holding reloaded during byte 1
      pulse_ld(8'h11);
      b = qq.size();
      sel_on();
      pulse_ld(8'h22);
      bits(8'h01, 8, 4, 1'b0, 8'h00, mi);
      chk("t2_miso0", mi, 8'h11);
      bits(8'h02, 8, 4, 1'b0, 8'h00, mi);
      chk("t2_miso1", mi, 8'h22);
      bits(8'h03, 8, 4, 1'b0, 8'h00, mi);
      chk("t2_miso2", mi, 8'hFF);
      sel_off();
      chk("t2_cnt", 8'(qq.size() - b), 8'd3);
      chk("t2_q0", qq[b], 8'h01);
      chk("t2_q1", qq[b+1], 8'h02);
      chk("t2_q2", qq[b+2], 8'h03);
      chk("t2_f0", {7'b0, fq[b]}, 8'd1);
      chk("t2_f1", {7'b0, fq[b+1]}, 8'd0);
      chk("t2_f2", {7'b0, fq[b+2]}, 8'd0);

      // 3: aborted partial byte, then fresh frame
      b = qq.size();
      sel_on();
      bits(8'hE3, 5, 4, 1'b0, 8'h00, mi);
      sel_off();
      chk("t3_partial_cnt", 8'(qq.size() - b), 8'd0);
      sel_on();
      bits(8'h5A, 8, 4, 1'b0, 8'h00, mi);
      sel_off();
      chk("t3_cnt", 8'(qq.size() - b), 8'd1);
      chk("t3_q", qq[b], 8'h5A);
      chk("t3_first", {7'b0, fq[b]}, 8'd1);

      // 4: ld coincident with the byte-boundary load while empty
      chk("t4_txe_pre", {7'b0, sif.txe}, 8'd1);
      b = qq.size();
      sel_on();
      bits(8'hF0, 8, 4, 1'b1, 8'h77, mi);
      chk("t4_miso0", mi, 8'hFF);
      chk("t4_txe_held", {7'b0, sif.txe}, 8'd0);
      bits(8'h0F, 8, 4, 1'b0, 8'h00, mi);
      chk("t4_miso1", mi, 8'hFF);
      chk("t4_txe_still", {7'b0, sif.txe}, 8'd0);
      bits(8'hAA, 8, 4, 1'b0, 8'h00, mi);
      chk("t4_miso2", mi, 8'h77);
      repeat (6) @(negedge clock);
      chk("t4_txe_after", {7'b0, sif.txe}, 8'd1);
      sel_off();
      chk("t4_cnt", 8'(qq.size() - b), 8'd3);
      chk("t4_q2", qq[b+2], 8'hAA);

      // 5: reset mid-byte
      sel_on();
      pulse_ld(8'h5E);
      bits(8'h99, 4, 4, 1'b0, 8'h00, mi);
      b = qq.size();
      reset = 1'b0;
      sif.ss_n = 1'b1;
      @(negedge clock);
      chk("t5_q", sif.q, 8'h00);
      chk("t5_rdy", {7'b0, sif.rdy}, 8'd0);
      chk("t5_first", {7'b0, sif.first}, 8'd0);
      chk("t5_sel", {7'b0, sif.sel}, 8'd0);
      chk("t5_oe", {7'b0, sif.oe}, 8'd0);
      chk("t5_miso", {7'b0, sif.miso}, 8'd1);
      chk("t5_txe", {7'b0, sif.txe}, 8'd1);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (5) @(negedge clock);
      sel_on();
      bits(8'hC3, 8, 4, 1'b0, 8'h00, mi);
      chk("t5_miso_fill", mi, 8'hFF);
      sel_off();
      chk("t5_cnt", 8'(qq.size() - b), 8'd1);
      chk("t5_qc3", qq[b], 8'hC3);
      chk("t5_fc3", {7'b0, fq[b]}, 8'd1);

      // 6: four back-to-back bytes at clock/4
      pulse_ld(8'h96);
      b = qq.size();
      sel_on();
      bits(8'h81, 8, 2, 1'b0, 8'h00, mi);
      chk("t6_miso0", mi, 8'h96);
      bits(8'h42, 8, 2, 1'b0, 8'h00, mi);
      chk("t6_miso1", mi, 8'hFF);
      bits(8'hE7, 8, 2, 1'b0, 8'h00, mi);
      chk("t6_miso2", mi, 8'hFF);
      bits(8'h18, 8, 2, 1'b0, 8'h00, mi);
      chk("t6_miso3", mi, 8'hFF);
      sel_off();
      chk("t6_cnt", 8'(qq.size() - b), 8'd4);
      chk("t6_q0", qq[b], 8'h81);
      chk("t6_q1", qq[b+1], 8'h42);
      chk("t6_q2", qq[b+2], 8'hE7);
      chk("t6_q3", qq[b+3], 8'h18);
      chk("t6_f0", {7'b0, fq[b]}, 8'd1);
      chk("t6_f3", {7'b0, fq[b+3]}, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
